// File: rtl/cond_branch_pc_if.sv
`default_nettype none
// ============================================================================
//  Module   : cond_branch_pc_if
//  Brief    : Branch-op request bus and PC/return-stack status bus.
//  Revision : 1.0
// ============================================================================
interface cond_branch_pc_if;
    logic [7:0] Instruction;
    logic [7:0] Target;
    logic       CF;
    logic       ZF;
    logic       SF;
    logic       Branch_En;
    logic       Hold;
    logic [7:0] PC;
    logic       Taken;
    logic [2:0] Depth;
    logic       Overflow;
    logic       Underflow;

    modport master (
        output Instruction, Target, CF, ZF, SF, Branch_En, Hold,
        input  PC, Taken, Depth, Overflow, Underflow
    );

    modport slave (
        input  Instruction, Target, CF, ZF, SF, Branch_En, Hold,
        output PC, Taken, Depth, Overflow, Underflow
    );
endinterface
`default_nettype wire

// File: rtl/cond_branch_pc.sv
`default_nettype none
// ============================================================================
//  Module   : cond_branch_pc
//  Brief    : Program counter with conditional jump/call/return and 4-deep
//             return stack with sticky overflow/underflow flags.
//  Revision : 1.0
// ============================================================================
module cond_branch_pc #(
    parameter int UUID = 0,
    parameter     NAME = ""
) (
    input  wire             clk,
    input  wire             rst,
    cond_branch_pc_if.slave bus
);
    localparam logic [1:0] c_kind_jump = 2'b00;
    localparam logic [1:0] c_kind_call = 2'b01;
    localparam logic [1:0] c_kind_ret  = 2'b10;
    localparam logic [2:0] c_depth_max = 3'd4;

    // Identification parameters carry no logic; this block never elaborates.
    generate
        if (UUID < 0 || $bits(NAME) == 0) begin : g_param_guard
        end
    endgenerate

    logic [7:0] r_pc;
    logic       r_taken;
    logic [2:0] r_depth;
    logic       r_ovf;
    logic       r_unf;
    logic [7:0] r_stack [0:3];

    logic [7:0] w_pc_inc;
    logic [1:0] w_top_idx;
    logic       w_cond_raw;
    logic       w_cond;
    logic [1:0] w_kind;
    logic [7:0] w_pc_nxt;
    logic       w_taken_nxt;
    logic [2:0] w_depth_nxt;
    logic       w_ovf_nxt;
    logic       w_unf_nxt;
    logic       w_push;
    logic       w_unused;

    assign w_pc_inc  = r_pc + 8'd1;
    assign w_top_idx = r_depth[1:0] - 2'd1;
    assign w_kind    = bus.Instruction[5:4];
    assign w_unused  = &{1'b0, bus.Instruction[7:6]};

    always_comb begin
        w_cond_raw = 1'b0;
        case (bus.Instruction[2:0])
            3'd0:    w_cond_raw = 1'b1;
            3'd1:    w_cond_raw = bus.ZF;
            3'd2:    w_cond_raw = bus.CF;
            3'd3:    w_cond_raw = bus.SF;
            3'd4:    w_cond_raw = bus.CF | bus.ZF;
            3'd5:    w_cond_raw = bus.SF ^ bus.CF;
            3'd6:    w_cond_raw = bus.ZF | bus.SF;
            default: w_cond_raw = 1'b0;
        endcase
        w_cond = w_cond_raw ^ bus.Instruction[3];
    end

    // Failed or suppressed ops fall through to sequential PC increment.
    always_comb begin
        w_pc_nxt    = w_pc_inc;
        w_taken_nxt = 1'b0;
        w_depth_nxt = r_depth;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        w_push      = 1'b0;
        if (bus.Branch_En && w_cond) begin
            case (w_kind)
                c_kind_jump: begin
                    w_pc_nxt    = bus.Target;
                    w_taken_nxt = 1'b1;
                end
                c_kind_call: begin
                    if (r_depth == c_depth_max) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_depth_nxt = r_depth + 3'd1;
                        w_pc_nxt    = bus.Target;
                        w_taken_nxt = 1'b1;
                    end
                end
                c_kind_ret: begin
                    if (r_depth == 3'd0) begin
                        w_unf_nxt = 1'b1;
                    end else begin
                        w_depth_nxt = r_depth - 3'd1;
                        w_pc_nxt    = r_stack[w_top_idx];
                        w_taken_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= 8'd0;
            r_taken <= 1'b0;
            r_depth <= 3'd0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (bus.Hold) begin
            r_taken <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_taken <= w_taken_nxt;
            r_depth <= w_depth_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    // Stack storage is not reset; Depth alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && !bus.Hold && w_push) begin
            r_stack[r_depth[1:0]] <= w_pc_inc;
        end
    end

    assign bus.PC        = r_pc;
    assign bus.Taken     = r_taken;
    assign bus.Depth     = r_depth;
    assign bus.Overflow  = r_ovf;
    assign bus.Underflow = r_unf;
endmodule
`default_nettype wire

// File: doc/cond_branch_pc.md
COND_BRANCH_PC -- requirements
Module: cond_branch_pc

Interface
REQ-001 SHALL have parameter UUID, default 0, instance identifier.
REQ-002 SHALL have parameter NAME, default "", instance label.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port Instruction, input, 8, branch opcode; [2:0] condition select, [3] invert, [5:4] kind, [7:6] ignored.
REQ-006 SHALL have port Target, input, 8, jump/call destination address.
REQ-007 SHALL have ports CF, ZF, SF, input, 1 each, registered ALU flags.
REQ-008 SHALL have port Branch_En, input, 1, execute Instruction as control-flow op this cycle.
REQ-009 SHALL have port Hold, input, 1, stall; freezes all state.
REQ-010 SHALL have port PC, output, 8, current program counter, registered.
REQ-011 SHALL have port Taken, output, 1, registered pulse: previous cycle redirected PC.
REQ-012 SHALL have port Depth, output, 3, return-stack occupancy 0..4.
REQ-013 SHALL have ports Overflow and Underflow, output, 1 each, sticky stack error flags.

Function
REQ-014 SHALL evaluate cond from [2:0]: 0 always, 1 ZF, 2 CF, 3 SF, 4 CF|ZF, 5 SF^CF, 6 ZF|SF, 7 never; effective cond = cond XOR Instruction[3].
REQ-015 SHALL evaluate cond combinationally from CF/ZF/SF as sampled at the same edge that executes the op.
REQ-016 SHALL decode kind [5:4]: 00 jump, 01 call, 10 return, 11 no-op.
REQ-017 SHALL, with Hold=1, keep PC, stack, Depth, flags unchanged and drive Taken=0 next cycle; Hold has priority over Branch_En.
REQ-018 SHALL, with Hold=0 and Branch_En=0, set PC <= PC+1 mod 256 (255 wraps to 0), Taken <= 0.
REQ-019 SHALL, on jump with effective cond=1, set PC <= Target, Taken <= 1; cond=0: PC <= PC+1, Taken <= 0.
REQ-020 SHALL, on call with cond=1 and Depth<4, push PC+1 mod 256, Depth+1, PC <= Target, Taken <= 1.
REQ-021 SHALL, on call with cond=1 and Depth=4, not push, set Overflow <= 1, PC <= PC+1, Taken <= 0.
REQ-022 SHALL, on return with cond=1 and Depth>0, PC <= top of stack, pop, Depth-1, Taken <= 1.
REQ-023 SHALL, on return with cond=1 and Depth=0, set Underflow <= 1, PC <= PC+1, Taken <= 0.
REQ-024 SHALL treat any op with cond=0, and kind 11, as PC <= PC+1, Taken <= 0, stack untouched.
REQ-025 SHALL implement stack as 4-entry LIFO of 8-bit entries; Depth is the only occupancy indicator.
REQ-026 SHALL keep Overflow/Underflow set until reset; they do not block later ops.
REQ-027 SHALL have latency of one cycle: op sampled at edge N is reflected on PC/Taken after edge N.

Reset
REQ-028 SHALL, with rst=1 at an edge, set PC=0, Taken=0, Depth=0, Overflow=0, Underflow=0, regardless of Hold/Branch_En.
REQ-029 SHALL discard stack contents on reset; entries need no defined value.
REQ-030 SHALL, on reset asserted mid-sequence, abandon any in-flight call/return; first cycle after release is PC=0 -> PC=1 if idle.

Verification
REQ-031 Reset, then 256 idle cycles -> PC counts 0..255 then 0; Taken always 0.
REQ-032 PC=0x10, Branch_En, Instruction=0x01 (jump if ZF), Target=0x40, ZF=1 -> PC=0x40, Taken=1; same with ZF=0 -> PC=0x11, Taken=0; Instruction=0x09, ZF=0 -> PC=0x40.
REQ-033 Call (0x10) at PC=0x05, Target=0x80 -> PC=0x80, Depth=1; return (0x20) at PC=0x90 -> PC=0x06, Depth=0, Taken=1.
REQ-034 Five unconditional calls -> Depth=4 after fourth, fifth gives Overflow=1, PC=prev+1; return from Depth=0 -> Underflow=1, PC+1.
REQ-035 Hold=1 with Branch_En=1 jump -> PC unchanged, Taken=0; release -> op executes.
REQ-036 rst=1 with Depth=3, Overflow=1, Hold=1 -> next cycle PC=0, Depth=0, flags 0.
